// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit subtractor among N_REQ requesters.
// Optional SUB_CHECK_EN: recompute A - B in CAPTURE and raise a sticky err on disagreement.
module sub_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 64,
    parameter int IDX_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_bus,
    input  logic [N_REQ*WIDTH-1:0]   b_bus,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         result,
    output logic                     msb,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     sub_dv0,
    output logic [WIDTH-1:0]         sub_a,
    output logic [WIDTH-1:0]         sub_b,
    input  logic [WIDTH-1:0]         sub_result,
    input  logic                     sub_msb,
    output logic                     err,
    output logic [1:0]               state_dbg
);

    // Handshake: a requester holds req (and its operands) until the grant is
    // taken in IDLE; ack pulses for exactly one cycle in DONE, and the
    // requester must drop req the cycle after so the next IDLE does not re-serve it.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [WIDTH-1:0]   sub_a_q, sub_a_d;
    logic [WIDTH-1:0]   sub_b_q, sub_b_d;
    logic               sub_dv0_q, sub_dv0_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               msb_q, msb_d;
    logic               busy_q, busy_d;

    logic               found;
    int                 sel;

    // First set req bit at or above rr_ptr, wrapping at N_REQ-1 -> 0.
    always_comb begin
        int cand;
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        sub_a_d     = sub_a_q;
        sub_b_d     = sub_b_q;
        sub_dv0_d   = 1'b0;
        ack_d       = '0;
        result_d    = result_q;
        msb_d       = msb_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_idx_d = IDX_W'(sel);
                    sub_a_d     = a_bus[sel*WIDTH +: WIDTH];
                    sub_b_d     = b_bus[sel*WIDTH +: WIDTH];
                    sub_dv0_d   = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // sub_result was loaded by the subtractor on the negedge inside ISSUE.
                result_d           = sub_result;
                msb_d              = sub_msb;
                ack_d[grant_idx_q] = 1'b1;
                state_d            = S_DONE;
            end
            S_DONE: begin
                if (grant_idx_q == IDX_W'(N_REQ - 1)) rr_ptr_d = '0;
                else                                   rr_ptr_d = grant_idx_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            sub_a_q     <= '0;
            sub_b_q     <= '0;
            sub_dv0_q   <= 1'b0;
            ack_q       <= '0;
            result_q    <= '0;
            msb_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            sub_a_q     <= sub_a_d;
            sub_b_q     <= sub_b_d;
            sub_dv0_q   <= sub_dv0_d;
            ack_q       <= ack_d;
            result_q    <= result_d;
            msb_q       <= msb_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SUB_CHECK_EN
    logic             err_q, err_d;
    logic [WIDTH-1:0] chk_diff;

    always_comb begin
        chk_diff = sub_a_q - sub_b_q;
        err_d    = err_q;
        if (state_q == S_CAPTURE &&
            ((chk_diff != sub_result) || ((sub_a_q < sub_b_q) != sub_msb)))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ack       = ack_q;
    assign result    = result_q;
    assign msb       = msb_q;
    assign busy      = busy_q;
    assign grant_idx = grant_idx_q;
    assign sub_dv0   = sub_dv0_q;
    assign sub_a     = sub_a_q;
    assign sub_b     = sub_b_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed bench for sub_arbiter: requesters drive req/operands, a behavioural
// subtractor answers on negedge, and a monitor scores each ack against exp_q.
module tb_sub_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int IW = 2;
  localparam int EW = IW + 1 + W;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus, b_bus;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           msb, busy;
  logic [IW-1:0]  grant_idx;
  logic           sub_dv0;
  logic [W-1:0]   sub_a, sub_b, sub_result;
  logic           sub_msb;
  logic           err;
  logic [1:0]     state_dbg;

  logic           inject;
  logic [N-1:0]   hold;
  logic [EW-1:0]  exp_q[$];
  int             n_total;
  int             n_bad;

  sub_arbiter #(.N_REQ(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .ack(ack), .result(result), .msb(msb), .busy(busy), .grant_idx(grant_idx),
    .sub_dv0(sub_dv0), .sub_a(sub_a), .sub_b(sub_b), .sub_result(sub_result),
    .sub_msb(sub_msb), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset-independent environment
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural subtractor: registers on negedge, inject corrupts the result by -2
  initial sub_result = '0;
  always @(negedge clk) begin
    if (sub_dv0) sub_result <= sub_a - sub_b - (inject ? 64'd2 : 64'd0);
  end
  assign sub_msb = (sub_a < sub_b);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
    req[i] = 1'b1;
  endtask

  task automatic expect_ack(input int i, input logic [W-1:0] r, input logic m);
    exp_q.push_back({IW'(i), m, r});
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (ack[i] && !hold[i]) req[i] = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!(exp_q.size() == 0 && !busy && req == '0) && c < 300);
    if (c >= 300) begin
      n_total++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (ack !== '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", W'(ack), '0);
        end else begin
          e = exp_q.pop_front();
          check("ack", W'(ack), W'(1) << e[EW-1 -: IW]);
          check("result", result, e[W-1:0]);
          check("msb", W'(msb), W'(e[W]));
        end
      end
    end
  end

  initial begin
    int last, cyc, seen0;
    logic exp_err;
    n_total = 0;
    n_bad   = 0;
    inject  = 1'b0;
    hold    = '0;
    req     = '0;
    a_bus   = '0;
    b_bus   = '0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ack", W'(ack), '0);
    check("rst_result", result, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_dv0", W'(sub_dv0), '0);
    check("rst_state", W'(state_dbg), '0);
    rst = 1'b0;
    step();

    // single request with cycle-exact timing (rr_ptr -> 1)
    raise(0, 64'd10, 64'd3);
    expect_ack(0, 64'd7, 1'b0);
    step();
    check("c1_dv0", W'(sub_dv0), 1);
    check("c1_busy", W'(busy), 1);
    check("c1_grant", W'(grant_idx), 0);
    check("c1_sub_a", sub_a, 64'd10);
    check("c1_sub_b", sub_b, 64'd3);
    check("c1_ack", W'(ack), 0);
    step();
    check("c2_dv0", W'(sub_dv0), 0);
    check("c2_busy", W'(busy), 1);
    check("c2_ack", W'(ack), 0);
    step();
    check("c3_ack", W'(ack), 1);
    check("c3_busy", W'(busy), 1);
    step();
    check("c4_busy", W'(busy), 0);
    check("c4_ack", W'(ack), 0);
    check("hold_sub_a", sub_a, 64'd10);
    drain();

    // borrow cases (requester 1 then 3; rr_ptr ends at 0)
    raise(1, 64'd3, 64'd10);
    expect_ack(1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
    drain();
    raise(3, 64'd0, 64'd1);
    expect_ack(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();

    // contention: all four from rr_ptr=0, then 0101 from rr_ptr=0
    raise(0, 64'd100, 64'd40);
    raise(1, 64'd200, 64'd1);
    raise(2, 64'd7, 64'd8);
    raise(3, 64'h8000_0000_0000_0000, 64'd1);
    expect_ack(0, 64'd60, 1'b0);
    expect_ack(1, 64'd199, 1'b0);
    expect_ack(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    expect_ack(3, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    drain();
    raise(0, 64'd1, 64'd1);
    raise(2, 64'd9, 64'd4);
    expect_ack(0, 64'd0, 1'b0);
    expect_ack(2, 64'd5, 1'b0);
    drain();

    // fairness: req0 held across two of its acks, req2 once; rr_ptr starts at 3
    hold = 4'b0001;
    raise(0, 64'd100, 64'd1);
    raise(2, 64'd5, 64'd5);
    expect_ack(0, 64'd99, 1'b0);
    expect_ack(2, 64'd0, 1'b0);
    expect_ack(0, 64'd99, 1'b0);
    last  = -1;
    cyc   = 0;
    seen0 = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        if (last >= 0) check("fair_gap_le8", W'(cyc - last <= 8), 1);
        last = cyc;
      end
      if (ack[0]) begin
        seen0++;
        if (seen0 == 2) hold[0] = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (ack[i] && !hold[i]) req[i] = 1'b0;
    end
    hold = '0;
    drain();

    // reset during ISSUE: no ack, outputs cleared, rr_ptr back to 0
    raise(1, 64'd50, 64'd20);
    step();
    check("pre_rst_dv0", W'(sub_dv0), 1);
    rst = 1'b1;
    step();
    check("mrst_ack", W'(ack), 0);
    check("mrst_result", result, 0);
    check("mrst_msb", W'(msb), 0);
    check("mrst_busy", W'(busy), 0);
    check("mrst_grant", W'(grant_idx), 0);
    check("mrst_dv0", W'(sub_dv0), 0);
    check("mrst_sub_a", sub_a, 0);
    check("mrst_sub_b", sub_b, 0);
    check("mrst_err", W'(err), 0);
    req = '0;
    rst = 1'b0;
    repeat (5) step();
    raise(0, 64'd30, 64'd12);
    raise(3, 64'd12, 64'd30);
    expect_ack(0, 64'd18, 1'b0);
    expect_ack(3, 64'hFFFF_FFFF_FFFF_FFEE, 1'b1);
    drain();

    // corrupted subtractor result: err only with the checker compiled in
`ifdef SUB_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("err_before_fault", W'(err), 0);
    inject = 1'b1;
    raise(0, 64'd10, 64'd3);
    expect_ack(0, 64'd5, 1'b0);
    drain();
    check("err_after_fault", W'(err), W'(exp_err));
    inject = 1'b0;
    repeat (5) step();
    check("err_sticky", W'(err), W'(exp_err));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_cleared", W'(err), 0);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
